// File: rtl/alu_pipe_hs_if.sv
// Operand/result handshake bundle for alu_pipe_hs: slave is the ALU side, master the surrounding datapath.
interface alu_pipe_hs_if #(
  parameter int NBITS = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] A;
  logic [NBITS-1:0] B;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS:0]   Y;
  logic             co;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, Y, co
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, Y, co
  );
endinterface

// File: rtl/alu_pipe_hs.sv
// Eight-op ALU, STAGES-deep valid/ready pipeline; latency STAGES, 1 op/cycle, capacity STAGES.
// Backpressure: empty stages collapse bubbles; in_ready is combinational from out_ready through the chain.
module alu_pipe_hs #(
  parameter int NBITS  = 8,
  parameter int STAGES = 2
) (
  input logic         clk,
  input logic         arst,
  input logic         flush,
  alu_pipe_hs_if.slave bus
);

  localparam int LAST = STAGES - 1;

  logic [NBITS:0]    w_a;
  logic [NBITS:0]    w_b;
  logic [NBITS:0]    w_y;
  logic              w_co;
  logic [STAGES:0]   w_adv;
  logic              w_in_ready;
  logic              w_accept;

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_co;
  logic [NBITS:0]    r_y [STAGES];

  assign w_a = {1'b0, bus.A};
  assign w_b = {1'b0, bus.B};

  always_comb begin
    w_y  = '0;
    w_co = 1'b0;
    case (bus.opcode)
      3'b000: begin
        w_y  = w_a + w_b;
        w_co = w_y[NBITS];
      end
      3'b001: begin
        w_y  = w_a - w_b;
        w_co = w_y[NBITS];
      end
      3'b010: w_y = w_a & w_b;
      3'b011: w_y = w_a | w_b;
      3'b100: w_y = w_a ^ w_b;
      3'b101: w_y = {1'b0, ~bus.A};
      3'b110: begin
        w_y  = {bus.A, 1'b0};
        w_co = bus.A[NBITS-1];
      end
      default: begin
        w_y  = {2'b00, bus.A[NBITS-1:1]};
        w_co = bus.A[0];
      end
    endcase
  end

  // w_adv[k]: stage k loads this cycle; w_adv[STAGES] stands for the consumer.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = !r_vld[k] || w_adv[k+1];
    end
  end

  assign w_in_ready = !flush && w_adv[0];
  assign w_accept   = bus.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_vld <= '0;
      r_co  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_y[k] <= '0;
      end
    end else begin
      // Payload only moves with a valid token so Y/co hold while out_valid is low.
      if (w_adv[0]) begin
        r_vld[0] <= w_accept;
        if (w_accept) begin
          r_y[0]  <= w_y;
          r_co[0] <= w_co;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_y[k]  <= r_y[k-1];
            r_co[k] <= r_co[k-1];
          end
        end
      end
      if (flush) begin
        r_vld <= '0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld[LAST];
  assign bus.Y         = r_y[LAST];
  assign bus.co        = r_co[LAST];

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Bench for alu_pipe_hs: directed vector table, handshake corner sequences and a randomized scoreboard run.
module tb_alu_pipe_hs;

  localparam int NB = 8;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] y;
    logic       co;
  } vec_t;

  logic       clk = 1'b0;
  logic       arst;
  logic       flush_a;
  logic       flush_b;
  int         total = 0;
  int         bad = 0;
  int         k;
  vec_t       vt [10];
  logic [9:0] exp_r;
  logic [9:0] m_e;
  logic [9:0] q_a [$];
  bit         hold_prev = 1'b0;
  logic [8:0] prev_y;
  logic       prev_co;

  always #5 clk = ~clk;

  alu_pipe_hs_if #(.NBITS(NB)) ifa ();
  alu_pipe_hs_if #(.NBITS(NB)) ifb ();

  alu_pipe_hs #(.NBITS(NB), .STAGES(2)) dut_a (.clk(clk), .arst(arst), .flush(flush_a), .bus(ifa));
  alu_pipe_hs #(.NBITS(NB), .STAGES(3)) dut_b (.clk(clk), .arst(arst), .flush(flush_b), .bus(ifb));

  // Reference: {co, Y} from plain integer arithmetic on 8-bit operands.
  function automatic logic [9:0] alu_ref(input int op, input int a, input int b);
    int y;
    int c;
    y = 0;
    c = 0;
    case (op)
      0: begin y = a + b; c = (y > 255) ? 1 : 0; end
      1: begin y = (a - b + 512) % 512; c = (a < b) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = 255 - a;
      6: begin y = (a * 2) % 512; c = a / 128; end
      default: begin y = a / 2; c = a % 2; end
    endcase
    return {c[0], y[8:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit rdy);
    ifa.in_valid  = v;
    ifa.opcode    = op;
    ifa.A         = a;
    ifa.B         = b;
    ifa.out_ready = rdy;
  endtask

  task automatic drv_b(input bit v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input bit rdy);
    ifb.in_valid  = v;
    ifb.opcode    = op;
    ifb.A         = a;
    ifb.B         = b;
    ifb.out_ready = rdy;
  endtask

  // Scoreboard for the 2-stage instance: in-order queue, occupancy-based in_ready, hold-while-stalled.
  always @(negedge clk) begin
    if (!arst) begin
      q_a.delete();
      hold_prev = 1'b0;
      chk("mon rst out_valid", 32'(ifa.out_valid), 0);
      chk("mon rst Y", 32'(ifa.Y), 0);
      chk("mon rst co", 32'(ifa.co), 0);
    end else begin
      chk("mon in_ready", 32'(ifa.in_ready), 32'(!flush_a && (q_a.size() < 2 || ifa.out_ready)));
      if (hold_prev) begin
        chk("mon hold out_valid", 32'(ifa.out_valid), 1);
        chk("mon hold Y", 32'(ifa.Y), 32'(prev_y));
        chk("mon hold co", 32'(ifa.co), 32'(prev_co));
      end
      if (ifa.out_valid && ifa.out_ready) begin
        if (q_a.size() == 0) begin
          chk("mon spurious result", 1, 0);
        end else begin
          m_e = q_a.pop_front();
          chk("mon result Y", 32'(ifa.Y), 32'(m_e[8:0]));
          chk("mon result co", 32'(ifa.co), 32'(m_e[9]));
        end
      end
      if (flush_a) begin
        q_a.delete();
      end else if (ifa.in_valid && ifa.in_ready) begin
        q_a.push_back(alu_ref(int'(ifa.opcode), int'(ifa.A), int'(ifa.B)));
      end
      hold_prev = ifa.out_valid && !ifa.out_ready && !flush_a;
      prev_y    = ifa.Y;
      prev_co   = ifa.co;
    end
  end

  initial begin
    arst    = 1'b0;
    flush_a = 1'b0;
    flush_b = 1'b0;
    drv_a(0, 0, 0, 0, 1);
    drv_b(0, 0, 0, 0, 0);

    vt[0] = '{3'd0, 8'd200,  8'd100,  9'h12C, 1'b1};
    vt[1] = '{3'd1, 8'd5,    8'd7,    9'h1FE, 1'b1};
    vt[2] = '{3'd6, 8'h81,   8'h00,   9'h102, 1'b1};
    vt[3] = '{3'd7, 8'h81,   8'h00,   9'h040, 1'b1};
    vt[4] = '{3'd5, 8'h0F,   8'h00,   9'h0F0, 1'b0};
    vt[5] = '{3'd2, 8'hA5,   8'h3C,   9'h024, 1'b0};
    vt[6] = '{3'd3, 8'hA5,   8'h3C,   9'h0BD, 1'b0};
    vt[7] = '{3'd4, 8'hA5,   8'h3C,   9'h099, 1'b0};
    vt[8] = '{3'd0, 8'hFF,   8'hFF,   9'h1FE, 1'b1};
    vt[9] = '{3'd1, 8'd7,    8'd5,    9'h002, 1'b0};

    repeat (2) tick();
    chk("reset out_valid", 32'(ifa.out_valid), 0);
    chk("reset Y", 32'(ifa.Y), 0);
    chk("reset co", 32'(ifa.co), 0);
    chk("reset in_ready", 32'(ifa.in_ready), 1);
    arst = 1'b1;

    // Single ops from the table: result appears exactly two edges after acceptance.
    for (int i = 0; i < 10; i++) begin
      drv_a(1, vt[i].op, vt[i].a, vt[i].b, 1);
      #1;
      chk("vec in_ready", 32'(ifa.in_ready), 1);
      tick();
      drv_a(0, 0, 0, 0, 1);
      chk("vec early out_valid", 32'(ifa.out_valid), 0);
      tick();
      chk("vec out_valid", 32'(ifa.out_valid), 1);
      chk("vec Y", 32'(ifa.Y), 32'(vt[i].y));
      chk("vec co", 32'(ifa.co), 32'(vt[i].co));
      tick();
    end

    // Back-to-back, one op per opcode.
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drv_a(1, 3'(c), 8'hA5, 8'h3C, 1);
      else       drv_a(0, 0, 0, 0, 1);
      #1;
      if (c < 8) chk("b2b in_ready", 32'(ifa.in_ready), 1);
      chk("b2b out_valid", 32'(ifa.out_valid), 32'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) begin
        exp_r = alu_ref(c - 2, 'hA5, 'h3C);
        chk("b2b Y", 32'(ifa.Y), 32'(exp_r[8:0]));
        chk("b2b co", 32'(ifa.co), 32'(exp_r[9]));
      end
      tick();
    end

    // Backpressure: two accepted, then stalled; release streams without gaps.
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drv_a(1, 0, 8'(10 + k), 8'd1, 0);
      #1;
      if (c >= 2) begin
        chk("bp stall out_valid", 32'(ifa.out_valid), 1);
        chk("bp stall Y", 32'(ifa.Y), 11);
      end
      if (ifa.in_ready) k++;
      tick();
    end
    chk("bp accepted", 32'(k), 2);
    for (int j = 0; j < 6; j++) begin
      drv_a(1, 0, 8'(10 + k), 8'd1, 1);
      #1;
      chk("bp run in_ready", 32'(ifa.in_ready), 1);
      chk("bp run out_valid", 32'(ifa.out_valid), 1);
      chk("bp run Y", 32'(ifa.Y), 32'(11 + j));
      if (ifa.in_ready) k++;
      tick();
    end
    drv_a(0, 0, 0, 0, 1);
    repeat (3) tick();

    // Bubble collapse on the 3-stage instance.
    drv_b(1, 0, 8'd1, 8'd1, 0);
    #1;
    chk("bub first in_ready", 32'(ifb.in_ready), 1);
    tick();
    drv_b(0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("bub held out_valid", 32'(ifb.out_valid), 1);
    chk("bub held Y", 32'(ifb.Y), 2);
    drv_b(1, 0, 8'd3, 8'd4, 0);
    #1;
    chk("bub stalled in_ready", 32'(ifb.in_ready), 1);
    tick();
    drv_b(0, 0, 0, 0, 0);
    tick();
    chk("bub still held Y", 32'(ifb.Y), 2);
    drv_b(0, 0, 0, 0, 1);
    #1;
    chk("bub rel1 out_valid", 32'(ifb.out_valid), 1);
    chk("bub rel1 Y", 32'(ifb.Y), 2);
    tick();
    chk("bub rel2 out_valid", 32'(ifb.out_valid), 1);
    chk("bub rel2 Y", 32'(ifb.Y), 7);
    tick();
    chk("bub empty", 32'(ifb.out_valid), 0);

    // Asynchronous reset with two results in flight.
    for (int c = 0; c < 2; c++) begin
      drv_a(1, 1, 8'(50 + c), 8'd3, 0);
      #1;
      chk("rst fill in_ready", 32'(ifa.in_ready), 1);
      tick();
    end
    drv_a(0, 0, 0, 0, 0);
    #1;
    chk("pre-reset out_valid", 32'(ifa.out_valid), 1);
    arst = 1'b0;
    #1;
    chk("async rst out_valid", 32'(ifa.out_valid), 0);
    chk("async rst Y", 32'(ifa.Y), 0);
    chk("async rst co", 32'(ifa.co), 0);
    tick();
    arst = 1'b1;
    drv_a(0, 0, 0, 0, 1);
    repeat (4) begin
      #1;
      chk("post-reset out_valid", 32'(ifa.out_valid), 0);
      tick();
    end

    // Flush with a full, stalled pipe and an op presented.
    for (int c = 0; c < 2; c++) begin
      drv_a(1, 2, 8'(8'hF0 + c), 8'h3C, 0);
      tick();
    end
    flush_a = 1'b1;
    drv_a(1, 3, 8'h55, 8'h0A, 0);
    #1;
    chk("flush in_ready", 32'(ifa.in_ready), 0);
    tick();
    flush_a = 1'b0;
    drv_a(0, 0, 0, 0, 1);
    repeat (4) begin
      #1;
      chk("post-flush out_valid", 32'(ifa.out_valid), 0);
      tick();
    end

    // Flush while a result is taken in the same cycle.
    drv_a(1, 0, 8'd9, 8'd9, 1);
    tick();
    drv_a(1, 0, 8'd1, 8'd2, 1);
    tick();
    flush_a = 1'b1;
    drv_a(1, 0, 8'd7, 8'd7, 1);
    #1;
    chk("flush2 out_valid", 32'(ifa.out_valid), 1);
    chk("flush2 Y", 32'(ifa.Y), 18);
    chk("flush2 in_ready", 32'(ifa.in_ready), 0);
    tick();
    flush_a = 1'b0;
    drv_a(0, 0, 0, 0, 1);
    repeat (3) begin
      #1;
      chk("post-flush2 out_valid", 32'(ifa.out_valid), 0);
      tick();
    end

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      flush_a = ($urandom_range(0, 99) < 3);
      drv_a($urandom_range(0, 99) < 70, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            $urandom_range(0, 99) < 60);
      tick();
    end
    flush_a = 1'b0;
    drv_a(0, 0, 0, 0, 1);
    repeat (5) tick();
    chk("drain queue empty", 32'(q_a.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe_hs.md
Name: alu_pipe_hs

Overview:
- Parametrised successor to the team's fixed-width, single-stage-option ALU.
- Eight-operation integer ALU with configurable operand width and configurable pipeline depth.
- Adds a valid/ready handshake on both sides, backpressure with bubble collapsing, and a synchronous flush.
- Sits between the operand sequencer and the accumulator path of the accelerator datapath.

Parameters:
- NBITS, 8, operand width in bits (>=2); result width is NBITS+1.
- STAGES, 2, number of register stages from operand capture to result (1..4).

Ports:
- clk  in  1  rising-edge clock.
- arst  in  1  asynchronous reset, active-low; one clock, no other reset.
- flush  in  1  synchronous pipeline clear, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block accepts bundle this cycle.
- A  in  NBITS  operand A, unsigned.
- B  in  NBITS  operand B, unsigned.
- opcode  in  3  operation select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result this cycle.
- Y  out  NBITS+1  result.
- co  out  1  carry/borrow/shift-out flag.

Behaviour:
- Opcodes; A and B are zero-extended to NBITS+1 unless noted:
  - 000 ADD: Y=A+B; co=Y[NBITS].
  - 001 SUB: Y=(A-B) mod 2^(NBITS+1); co=Y[NBITS] (borrow, A<B).
  - 010 AND, 011 OR, 100 XOR: Y[NBITS]=0; co=0.
  - 101 NOT: Y={0,~A}; co=0.
  - 110 SHL: Y={A,0}>>0 truncated to NBITS+1, i.e. Y=A<<1; co=A[NBITS-1].
  - 111 SHR: Y={0,A>>1} logical; co=A[0].
- Result is computed combinationally from the inputs and written into stage 0 on acceptance. Stages 1..STAGES-1 are pure delay registers holding {valid, Y, co}.
- Input transfer happens when in_valid && in_ready. Output transfer happens when out_valid && out_ready.
- Stage advance:
  - Last stage may load when it is empty or out_ready=1.
  - Stage k<last may load when it is empty or stage k+1 loads this cycle (bubble collapsing).
  - A stage that does not load holds its contents.
- in_ready = !flush && (stage0 empty || stage0 advances). This is combinational from out_ready through the chain; no register on in_ready.
- Latency:
  - Accepted at cycle n, visible at the outputs from cycle n+STAGES when not stalled.
  - Throughput is 1 op/cycle with out_ready held high.
  - Capacity is STAGES results; never more in flight.
- Ordering: results leave in acceptance order; no loss or duplication under any out_ready pattern.
- Y and co are held stable while out_valid=1 and out_ready=0.
- When out_valid=0, Y and co hold their last value; the bench must not check them.
- flush=1:
  - Clears all stage valid bits at the next edge.
  - in_ready=0 that cycle, so no input is accepted.
  - A result presented in that cycle with out_ready=1 still counts as transferred.
- arst low:
  - Immediately clears all valid bits and sets Y=0, co=0, out_valid=0.
  - in_ready follows its equation, so it is 1 once flush=0.
  - Mid-operation reset discards all in-flight results.
  - The first acceptance happens at the first rising edge after arst deasserts.
- Simultaneous accept and emit with a full pipe and out_ready=1: legal, occupancy unchanged.

Test Plan:
- NBITS=8, STAGES=2, out_ready=1: ADD A=200 B=100 -> after 2 cycles out_valid=1, Y=9'h12C, co=1; SUB A=5 B=7 -> Y=9'h1FE, co=1.
- SHL A=8'h81 -> Y=9'h102, co=1. SHR A=8'h81 -> Y=9'h040, co=1. NOT A=8'h0F -> Y=9'h0F0, co=0.
- Back-to-back: 8 ops on consecutive cycles (one per opcode, A=8'hA5, B=8'h3C), out_ready=1 -> 8 consecutive results starting at cycle 2, in order, in_ready never drops.
- Backpressure: out_ready=0, in_valid=1 continuously -> exactly 2 accepted, then in_ready=0. Y is stable over 5 stalled cycles. Raise out_ready -> both results emitted in order, then stream resumes with no gaps.
- Bubble collapse, STAGES=3: accept one op, stall 3 cycles, then accept another while still stalled -> the second op advances to stage 1 behind the held result; release gives two results on consecutive cycles.
- Reset/flush: assert arst low with 2 ops in flight -> out_valid=0, Y=0, co=0 immediately, nothing emitted after release. Assert flush with in_valid=1 -> in_ready=0, pipe empty next cycle, and the op presented during the flush is not accepted.
